// File: rtl/busca_instrucao.sv
// Generic first-word-fall-through FIFO with synchronous active-low reset.
// Latency: a pushed word is visible at head_dat the cycle after the push.
// Backpressure: push is dropped when full and pop ignored when empty; the owner keeps both legal.
module fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_vld,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [$clog2(DEPTH):0]   occ,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty    = (occ == '0);
    assign do_push  = push_vld && (occ != (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign head_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers are power-of-two wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            occ <= occ + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// Instruction fetch: walks pc over instruction memory and buffers words for the decoder.
// Latency: one cycle from start to first request; a word reaches _instrucao one cycle after its ack.
// Backpressure: decoder stalls fill the FIFO, after which requests pause until a slot frees up.
module busca_instrucao #(
    parameter int ADDR_W   = 8,
    parameter int DEPTH    = 4,
    parameter int PROG_LEN = 16
) (
    input  logic              _clock,
    input  logic              _reset_n,
    input  logic              _start,
    output logic              _imem_req,
    output logic [ADDR_W-1:0] _imem_addr,
    input  logic              _imem_ack,
    input  logic [31:0]       _imem_data,
    output logic [31:0]       _instrucao,
    output logic              _instr_valid,
    input  logic              _instr_ready,
    output logic              _busy,
    output logic              _done,
    output logic [ADDR_W:0]   _count
);
    localparam int                OW   = $clog2(DEPTH) + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(PROG_LEN - 1);
    localparam logic [ADDR_W:0]   PLEN = (ADDR_W+1)'(PROG_LEN);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_SPACE, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [OW-1:0]     occ;
    logic [OW-1:0]     occ_next;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    assign push         = _imem_req && _imem_ack;
    assign pop          = _instr_valid && _instr_ready;
    assign occ_next     = occ + OW'(push) - OW'(pop);
    assign _instr_valid = !fifo_empty;

    fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
        .clk      (_clock),
        .rst_n    (_reset_n),
        .push_vld (push),
        .push_dat (_imem_data),
        .pop      (pop),
        .head_dat (_instrucao),
        .occ      (occ),
        .empty    (fifo_empty)
    );

    always_ff @(posedge _clock) begin
        if (!_reset_n) begin
            state      <= IDLE;
            pc         <= '0;
            _imem_req  <= 1'b0;
            _imem_addr <= '0;
            _busy      <= 1'b0;
            _done      <= 1'b0;
            _count     <= '0;
        end else begin
            if (pop && _count != PLEN) _count <= _count + 1'b1;
            case (state)
                IDLE, DONE: begin
                    if (_start) begin
                        state      <= REQ;
                        pc         <= '0;
                        _imem_addr <= '0;
                        _imem_req  <= 1'b1;
                        _busy      <= 1'b1;
                        _done      <= 1'b0;
                        _count     <= '0;
                    end
                end
                REQ: begin
                    if (push) begin
                        pc <= pc + 1'b1;
                        if (pc == LAST) begin
                            state     <= DRAIN;
                            _imem_req <= 1'b0;
                        end else if (occ_next == OW'(DEPTH)) begin
                            state     <= WAIT_SPACE;
                            _imem_req <= 1'b0;
                        end else begin
                            _imem_addr <= pc + 1'b1;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (occ < OW'(DEPTH)) begin
                        state      <= REQ;
                        _imem_req  <= 1'b1;
                        _imem_addr <= pc;
                    end
                end
                DRAIN: begin
                    // Looking at occ_next lets the final pop itself finish the run.
                    if (occ_next == '0) begin
                        state <= DONE;
                        _busy <= 1'b0;
                        _done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_busca_instrucao.sv
// Randomized scoreboard bench for busca_instrucao: expected words are queued per run
// from the memory image, and a negedge monitor checks handshakes against that model.
module tb_busca_instrucao;
    localparam int AW    = 4;
    localparam int DEPTH = 4;
    localparam int PLEN  = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack = 1'b0;
    logic [31:0]   imem_data = '0;
    logic [31:0]   instrucao;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          busy;
    logic          done;
    logic [AW:0]   count;

    busca_instrucao #(.ADDR_W(AW), .DEPTH(DEPTH), .PROG_LEN(PLEN)) dut (
        ._clock       (clk),
        ._reset_n     (rst_n),
        ._start       (start),
        ._imem_req    (imem_req),
        ._imem_addr   (imem_addr),
        ._imem_ack    (imem_ack),
        ._imem_data   (imem_data),
        ._instrucao   (instrucao),
        ._instr_valid (instr_valid),
        ._instr_ready (instr_ready),
        ._busy        (busy),
        ._done        (done),
        ._count       (count)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [PLEN];
    logic [31:0] exp_q [$];
    int          mem_mode = 0;    // 0 zero-wait, 1 every 3rd cycle, 2 random, 3 manual
    int          ready_mode = 0;  // 0 always, 1 never, 2 random, 3 manual
    int          exp_addr = 0;
    int          popped = 0;
    bit          running = 0;
    bit          started = 0;
    bit          pend = 0;
    logic [AW-1:0] pend_addr = '0;
    int          cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory and decoder responders, driven after the main sequencer each cycle.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            imem_data = mem[imem_addr];
            case (mem_mode)
                0: imem_ack = imem_req;
                1: imem_ack = (cyc % 3 == 0);
                2: imem_ack = ($urandom_range(0, 2) != 0);
                default: ;
            endcase
            case (ready_mode)
                0: instr_ready = 1'b1;
                1: instr_ready = 1'b0;
                2: instr_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    // Monitor: compares everything the DUT presents against the run model.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                running  = 0;
                started  = 0;
                popped   = 0;
                exp_addr = 0;
                pend     = 0;
                continue;
            end
            check("busy", 64'(busy), 64'(running));
            check("done", 64'(done), 64'(started && !running));
            check("count", 64'(count), 64'(popped));
            if (!instr_valid) check("empty_head_zero", 64'(instrucao), 64'd0);
            if (pend) check("req_addr_hold", 64'({imem_req, imem_addr}), 64'({1'b1, pend_addr}));
            if (imem_req && !(running && exp_addr < PLEN)) begin
                checks++;
                errors++;
                $display("FAIL req_outside_run: got req=1 expected req=0 (acks so far %0d)", exp_addr);
            end
            if (imem_req && imem_ack) begin
                check("ack_addr", 64'(imem_addr), 64'(exp_addr[AW-1:0]));
                exp_addr++;
            end
            pend      = imem_req && !imem_ack;
            pend_addr = imem_addr;
            if (start && !running) begin
                running  = 1;
                started  = 1;
                popped   = 0;
                exp_addr = 0;
            end
            if (instr_valid && instr_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_word: got %08h expected no word", instrucao);
                end else begin
                    logic [31:0] w;
                    w = exp_q.pop_front();
                    if (instrucao !== w) begin
                        errors++;
                        $display("FAIL word: got %08h expected %08h", instrucao, w);
                    end
                end
                popped++;
                if (popped == PLEN) running = 0;
            end
        end
    end

    task automatic load_program(input bit fixed);
        for (int i = 0; i < PLEN; i++) mem[i] = $urandom;
        if (fixed) begin
            mem[0] = 32'h0000_0005;
            mem[1] = 32'h2000_0003;
            mem[2] = 32'h6000_0002;
            mem[3] = 32'hC800_0000;
        end
        exp_q.delete();
        for (int i = 0; i < PLEN; i++) exp_q.push_back(mem[i]);
    endtask

    task automatic wait_done(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: got done=0 expected done=1 within %0d cycles", budget);
        end
        check("words_left", 64'(exp_q.size()), 64'd0);
        check("final_count", 64'(count), 64'(PLEN));
        check("final_req", 64'(imem_req), 64'd0);
        tick();
    endtask

    task automatic run(input int mm, input int rm, input bit fixed, input bit extra_start);
        load_program(fixed);
        mem_mode   = mm;
        ready_mode = rm;
        start = 1'b1;
        tick();
        start = 1'b0;
        if (extra_start) begin
            repeat (5) tick();
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        wait_done(2000);
    endtask

    initial begin
        for (int i = 0; i < PLEN; i++) mem[i] = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req", 64'(imem_req), 64'd0);
        check("rst_addr", 64'(imem_addr), 64'd0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_instr", 64'(instrucao), 64'd0);
        tick();

        // Zero-wait memory, decoder always ready.
        run(0, 0, 1, 0);
        // Ack every third cycle.
        run(1, 0, 1, 0);

        // Stalled decoder: fill exactly DEPTH words, then requests stop.
        load_program(0);
        mem_mode   = 0;
        ready_mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        check("stall_req", 64'(imem_req), 64'd0);
        check("stall_acks", 64'(exp_addr), 64'(DEPTH));
        check("stall_valid", 64'(instr_valid), 64'd1);
        ready_mode = 0;
        wait_done(2000);

        // Ack and pop together at occupancy DEPTH-1 keeps requesting.
        load_program(0);
        mem_mode    = 3;
        ready_mode  = 3;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start    = 1'b0;
        imem_ack = 1'b1;
        repeat (3) tick();
        instr_ready = 1'b1;
        tick();
        check("occ3_req", 64'(imem_req), 64'd1);
        check("occ3_addr", 64'(imem_addr), 64'd4);
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        tick();
        check("occ3_still_req", 64'(imem_req), 64'd1);
        mem_mode   = 0;
        ready_mode = 0;
        wait_done(2000);

        // Reset mid-run with ack high aborts cleanly.
        load_program(0);
        mem_mode   = 0;
        ready_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("abort_req", 64'(imem_req), 64'd0);
        check("abort_valid", 64'(instr_valid), 64'd0);
        check("abort_instr", 64'(instrucao), 64'd0);
        tick();
        run(0, 2, 0, 0);

        // Restart from DONE, with an ignored start pulse mid-run.
        run(0, 0, 0, 1);

        for (int r = 0; r < 4; r++) run(2, 2, 0, r[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/busca_instrucao.md
Name: busca_instrucao

Overview:
Instruction fetch stage placed directly upstream of the control/decode unit. After a start pulse it walks a program counter through instruction memory over a req/ack handshake. Returned 32-bit words are buffered in a small FIFO. The head of the FIFO is presented to the decoder on _instrucao with a valid/ready handshake, so memory latency and decoder stalls are decoupled.

Parameters:
ADDR_W, 8, instruction memory address width (word addressed)
DEPTH, 4, FIFO entries (power of two, >=2)
PROG_LEN, 16, instructions per program run, legal range 1..2^ADDR_W

Ports:
_clock  input  1  rising-edge clock, sole clock domain
_reset_n  input  1  synchronous, active-low reset
_start  input  1  one-cycle pulse; begins a run from address 0 (honoured only in IDLE or DONE)
_imem_req  output  1  registered read request to instruction memory
_imem_addr  output  ADDR_W  registered word address, stable while _imem_req=1
_imem_ack  input  1  memory accepts request and returns data this cycle; ignored when _imem_req=0
_imem_data  input  32  instruction word, valid when _imem_ack=1
_instrucao  output  32  FIFO head to decoder (opcode [31:29], A [28:27], dest [26:25], imm [24:0]); 0 when empty
_instr_valid  output  1  FIFO non-empty
_instr_ready  input  1  decoder consumes head when _instr_valid & _instr_ready
_busy  output  1  high in REQ, WAIT_SPACE, DRAIN
_done  output  1  high in DONE
_count  output  ADDR_W+1  instructions delivered (popped) in current run

Behaviour:
- Reset (_reset_n=0 at edge) dominates all other inputs. Result: state IDLE, pc=0, FIFO empty, _imem_req=0, _imem_addr=0, _instr_valid=0, _instrucao=0, _busy=0, _done=0, _count=0.
- Reset mid-run aborts the run. An ack in the reset cycle is discarded, and no memory request is outstanding afterwards.
- States: IDLE, REQ, WAIT_SPACE, DRAIN, DONE.
- IDLE: on _start go to REQ with pc=0 and _count=0. _imem_req=1 and _imem_addr=0 from the next cycle.
- REQ: _imem_req=1, _imem_addr=pc. On _imem_ack:
  - push _imem_data into the FIFO and set pc<=pc+1;
  - if pc==PROG_LEN-1, go to DRAIN;
  - else if the occupancy after this cycle's push/pop equals DEPTH, go to WAIT_SPACE;
  - else stay in REQ, with the new address driven the next cycle. Back-to-back acks give one instruction per cycle.
- No ack: request and address are held unchanged indefinitely.
- WAIT_SPACE: _imem_req=0. Return to REQ the cycle after occupancy < DEPTH.
- DRAIN: _imem_req=0. Go to DONE when the FIFO is empty, including the cycle of the final pop.
- DONE: _done=1. _start restarts as from IDLE and clears _done and _count.
- _start is ignored in REQ, WAIT_SPACE and DRAIN.
- FIFO:
  - first-word-fall-through; _instrucao is combinational from the head entry;
  - push and pop in the same cycle leave occupancy unchanged; this is legal at any occupancy, including DEPTH-1;
  - no push is possible when full, because _imem_req=0 outside REQ and REQ never holds with a full FIFO;
  - pointers wrap modulo DEPTH.
- _count increments on each pop and saturates at PROG_LEN.
- pc wraps modulo 2^ADDR_W. Only reachable when PROG_LEN=2^ADDR_W, where the final address is 2^ADDR_W-1.
- Word order at _instrucao equals address order; no word is duplicated or dropped.

Test Plan:
1. PROG_LEN=4, zero-wait memory (ack=req), words 0x00000005, 0x20000003, 0x60000002, 0xC8000000, _instr_ready=1 → the 4 words leave in order on consecutive cycles after fill; _done=1 when the FIFO empties; _count=4.
2. Memory acks every 3rd cycle → _imem_addr holds its value during wait cycles; no ack-less push; same output order as scenario 1.
3. _instr_ready=0, PROG_LEN=16, DEPTH=4 → exactly 4 acks then WAIT_SPACE with _imem_req=0. Raise ready → fetch resumes at address 4.
4. Occupancy 3, ack and pop in the same cycle → occupancy stays 3 and state stays REQ.
5. Assert _reset_n=0 mid-run with ack high → next cycle IDLE, _instr_valid=0, _imem_req=0. A later _start refetches from address 0.
6. In DONE, pulse _start; in REQ, pulse _start → DONE restarts from address 0 with _count=0; the pulse in REQ is ignored and pc is unchanged.
